// File: rtl/uart_pkg.sv
// Shared UART types: FSM state encodings and the even-parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    function automatic logic even_parity(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronized input, mid-bit sampling, glitch-rejecting start.
module uart_rx #(
    parameter int CLK_BITS    = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_BITS = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CLK_BITS-1:0]   clk_per_bit,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  done,
    output logic                  parity_error
);
    import uart_pkg::*;

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    rx_state_e             state;
    logic                  s1, s2, prev;
    logic [CLK_BITS-1:0]   cnt;
    logic [CLK_BITS-1:0]   bit_len;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IW-1:0]         idx;
    logic                  par_bit;

    wire [CLK_BITS-1:0] len_in = (clk_per_bit == '0) ? CLK_BITS'(1) : clk_per_bit;
    wire [CLK_BITS-1:0] half = ((len_in >> 1) == '0) ? CLK_BITS'(1) : (len_in >> 1);
    wire [CLK_BITS-1:0] reload = bit_len - CLK_BITS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            prev         <= 1'b1;
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_len      <= CLK_BITS'(1);
            shreg        <= '0;
            idx          <= '0;
            par_bit      <= 1'b0;
            data         <= '0;
            done         <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            s1   <= line;
            s2   <= s1;
            prev <= s2;
            done <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (prev && !s2) begin
                        state   <= RX_START;
                        bit_len <= len_in;
                        cnt     <= half - CLK_BITS'(1);
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else if (s2) begin
                        state <= RX_IDLE;
                    end else begin
                        state <= RX_DATA;
                        cnt   <= reload;
                        idx   <= '0;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else begin
                        cnt   <= reload;
                        shreg <= {s2, shreg[DATA_WIDTH-1:1]};
                        if (idx != LAST_IDX) begin
                            idx <= idx + IW'(1);
                        end else begin
                            state <= (PARITY_BITS != 0) ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else begin
                        state   <= RX_STOP;
                        cnt     <= reload;
                        par_bit <= s2;
                    end
                end
                RX_STOP: begin
                    // stop level is not checked; the byte is delivered regardless
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else begin
                        state        <= RX_IDLE;
                        done         <= 1'b1;
                        data         <= shreg;
                        parity_error <= (PARITY_BITS != 0) &&
                                        (par_bit != even_parity(32'(shreg)));
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional even parity, stop bits.
module uart_tx #(
    parameter int CLK_BITS    = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_BITS = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CLK_BITS-1:0]   clk_per_bit,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  en,
    output logic                  line,
    output logic                  done,
    output logic                  busy
);
    import uart_pkg::*;

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic SINGLE_STOP = 1'(STOP_BITS == 1);

    tx_state_e             state;
    logic [CLK_BITS-1:0]   cnt;
    logic [CLK_BITS-1:0]   bit_len;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IW-1:0]         idx;
    logic                  par;
    logic                  stop_idx;

    wire [CLK_BITS-1:0] len_in = (clk_per_bit == '0) ? CLK_BITS'(1) : clk_per_bit;
    wire [CLK_BITS-1:0] reload = bit_len - CLK_BITS'(1);
    wire                one_cycle = (bit_len == CLK_BITS'(1));

    // done is registered, so it is raised one cycle ahead of the last stop cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            bit_len  <= CLK_BITS'(1);
            shreg    <= '0;
            idx      <= '0;
            par      <= 1'b0;
            stop_idx <= 1'b0;
            line     <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (en) begin
                        state   <= TX_START;
                        busy    <= 1'b1;
                        line    <= 1'b0;
                        bit_len <= len_in;
                        cnt     <= len_in - CLK_BITS'(1);
                        shreg   <= data;
                        par     <= even_parity(32'(data));
                        idx     <= '0;
                    end
                end
                TX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else begin
                        state <= TX_DATA;
                        line  <= shreg[0];
                        cnt   <= reload;
                    end
                end
                TX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else begin
                        cnt   <= reload;
                        shreg <= shreg >> 1;
                        if (idx != LAST_IDX) begin
                            idx  <= idx + IW'(1);
                            line <= shreg[1];
                        end else if (PARITY_BITS != 0) begin
                            state <= TX_PARITY;
                            line  <= par;
                        end else begin
                            state    <= TX_STOP;
                            line     <= 1'b1;
                            stop_idx <= 1'b0;
                            done     <= SINGLE_STOP && one_cycle;
                        end
                    end
                end
                TX_PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CLK_BITS'(1);
                    end else begin
                        state    <= TX_STOP;
                        line     <= 1'b1;
                        cnt      <= reload;
                        stop_idx <= 1'b0;
                        done     <= SINGLE_STOP && one_cycle;
                    end
                end
                TX_STOP: begin
                    if (cnt != '0) begin
                        cnt  <= cnt - CLK_BITS'(1);
                        done <= (cnt == CLK_BITS'(1)) && (stop_idx == LAST_STOP);
                    end else if (stop_idx == LAST_STOP) begin
                        state <= TX_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        stop_idx <= 1'b1;
                        cnt      <= reload;
                        done     <= one_cycle;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_txrx_wrapper.sv
// Full-duplex UART: independent transmitter and receiver on one clock.
module uart_txrx_wrapper #(
    parameter int CLK_BITS    = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_BITS = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CLK_BITS-1:0]   clk_per_bit,
    input  logic [DATA_WIDTH-1:0] TX_dataIn,
    input  logic                  TX_en,
    input  logic                  RX_dataIn,
    output logic                  TX_out,
    output logic                  TX_done,
    output logic                  TX_busy,
    output logic [DATA_WIDTH-1:0] RX_dataOut,
    output logic                  RX_done,
    output logic                  RX_parityError
);

    uart_tx #(
        .CLK_BITS(CLK_BITS), .DATA_WIDTH(DATA_WIDTH),
        .PARITY_BITS(PARITY_BITS), .STOP_BITS(STOP_BITS)
    ) u_tx (
        .clk(clk), .rst_n(rst_n), .clk_per_bit(clk_per_bit),
        .data(TX_dataIn), .en(TX_en),
        .line(TX_out), .done(TX_done), .busy(TX_busy)
    );

    uart_rx #(
        .CLK_BITS(CLK_BITS), .DATA_WIDTH(DATA_WIDTH),
        .PARITY_BITS(PARITY_BITS)
    ) u_rx (
        .clk(clk), .rst_n(rst_n), .clk_per_bit(clk_per_bit),
        .line(RX_dataIn), .data(RX_dataOut),
        .done(RX_done), .parity_error(RX_parityError)
    );

endmodule

// File: tb/tb_uart_txrx_wrapper.sv
// Bench for uart_txrx_wrapper: TX frame table, loopback scoreboard,
// parity/glitch receive cases and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_txrx_wrapper;

    typedef struct {
        logic [7:0] data;
        logic [7:0] cpb;
        logic       loop;
        logic [9:0] frame;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] clk_per_bit = 8'd8;
    logic [7:0] tx_data0 = '0, tx_data1 = '0;
    logic       tx_en0 = 1'b0, tx_en1 = 1'b0;
    logic       loop = 1'b0, rx_drv0 = 1'b1, rx_drv1 = 1'b1;
    logic       rx_in0;
    logic       tx_out0, tx_done0, tx_busy0, rx_done0, rx_perr0;
    logic       tx_out1, tx_done1, tx_busy1, rx_done1, rx_perr1;
    logic [7:0] rx_data0, rx_data1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    vec_t vecs[6];
    logic [7:0] bb[3];
    int stamp[3];
    int nvec = 0, nmis = 0;
    int ndone0 = 0, ndone1 = 0, ntxdone = 0, exp_tx = 0, cyc = 0;
    int n0, t0, acc, guard;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_in0 = loop ? tx_out0 : rx_drv0;

    uart_txrx_wrapper #(
        .CLK_BITS(8), .DATA_WIDTH(8), .PARITY_BITS(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_per_bit(clk_per_bit),
        .TX_dataIn(tx_data0), .TX_en(tx_en0), .RX_dataIn(rx_in0),
        .TX_out(tx_out0), .TX_done(tx_done0), .TX_busy(tx_busy0),
        .RX_dataOut(rx_data0), .RX_done(rx_done0),
        .RX_parityError(rx_perr0)
    );

    uart_txrx_wrapper #(
        .CLK_BITS(8), .DATA_WIDTH(8), .PARITY_BITS(1), .STOP_BITS(1)
    ) dut_par (
        .clk(clk), .rst_n(rst_n), .clk_per_bit(clk_per_bit),
        .TX_dataIn(tx_data1), .TX_en(tx_en1), .RX_dataIn(rx_drv1),
        .TX_out(tx_out1), .TX_done(tx_done1), .TX_busy(tx_busy1),
        .RX_dataOut(rx_data1), .RX_done(rx_done1),
        .RX_parityError(rx_perr1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe);
        exp_t e;
        e.d = d;
        e.pe = pe;
        return e;
    endfunction

    // Scoreboard: every RX_done pops the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_done0) ntxdone++;
            if (rx_done0) begin
                ndone0++;
                if (q0.size() == 0) begin
                    chk("rx0_unexpected_done", 32'(rx_data0), 32'hFFFF_FFFF);
                end else begin
                    m0 = q0.pop_front();
                    chk("rx0_data", 32'(rx_data0), 32'(m0.d));
                    chk("rx0_perr", 32'(rx_perr0), 32'(m0.pe));
                end
            end
            if (rx_done1) begin
                ndone1++;
                if (q1.size() == 0) begin
                    chk("rx1_unexpected_done", 32'(rx_data1), 32'hFFFF_FFFF);
                end else begin
                    m1 = q1.pop_front();
                    chk("rx1_data", 32'(rx_data1), 32'(m1.d));
                    chk("rx1_perr", 32'(rx_perr1), 32'(m1.pe));
                end
            end
        end
    end

    task automatic tx_frame(input vec_t v);
        int n;
        n = (v.cpb == 8'd0) ? 1 : int'(v.cpb);
        clk_per_bit = v.cpb;
        loop = v.loop;
        tx_data0 = v.data;
        tx_en0 = 1'b1;
        @(negedge clk);
        tx_en0 = 1'b0;
        tx_data0 = ~v.data;
        exp_tx++;
        if (v.loop) q0.push_back(mk(v.data, 1'b0));
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < n; k++) begin
                if (b == 3 && k == 0) clk_per_bit = v.cpb + 8'd5;
                chk("tx_out", 32'(tx_out0), 32'(v.frame[b]));
                chk("tx_busy", 32'(tx_busy0), 32'd1);
                chk("tx_done", 32'(tx_done0), 32'(b == 9 && k == n - 1));
                @(negedge clk);
            end
        end
        chk("tx_end_busy", 32'(tx_busy0), 32'd0);
        chk("tx_end_out", 32'(tx_out0), 32'd1);
        clk_per_bit = v.cpb;
    endtask

    task automatic send_rx(input logic sel, input logic [7:0] d,
                           input logic par, input logic stp, input int cpb);
        logic [10:0] f;
        int nb;
        if (sel) begin
            f = {stp, par, d, 1'b0};
            nb = 11;
        end else begin
            f = {1'b1, stp, d, 1'b0};
            nb = 10;
        end
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < cpb; k++) begin
                if (sel) rx_drv1 = f[b];
                else rx_drv0 = f[b];
                @(negedge clk);
            end
        end
        rx_drv0 = 1'b1;
        rx_drv1 = 1'b1;
        repeat (cpb) @(negedge clk);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{8'hA5, 8'd8, 1'b1, {1'b1, 8'hA5, 1'b0}};
        vecs[1] = '{8'h3C, 8'd3, 1'b1, {1'b1, 8'h3C, 1'b0}};
        vecs[2] = '{8'h01, 8'd1, 1'b0, {1'b1, 8'h01, 1'b0}};
        vecs[3] = '{8'h80, 8'd0, 1'b0, {1'b1, 8'h80, 1'b0}};
        vecs[4] = '{8'hFF, 8'd5, 1'b1, {1'b1, 8'hFF, 1'b0}};
        vecs[5] = '{8'h00, 8'd4, 1'b1, {1'b1, 8'h00, 1'b0}};
        bb = '{8'h00, 8'hFF, 8'h3C};

        repeat (3) @(negedge clk);
        chk("rst_tx_out", 32'(tx_out0), 32'd1);
        chk("rst_tx_busy", 32'(tx_busy0), 32'd0);
        chk("rst_tx_done", 32'(tx_done0), 32'd0);
        chk("rst_rx_data", 32'(rx_data0), 32'd0);
        chk("rst_rx_done", 32'(rx_done0), 32'd0);
        chk("rst_rx_perr", 32'(rx_perr1), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tx_out", 32'(tx_out0), 32'd1);

        for (int i = 0; i < 6; i++) begin
            tx_frame(vecs[i]);
            repeat (6) @(negedge clk);
        end

        // TX_en held high, data churning; only idle-cycle bytes go out
        clk_per_bit = 8'd16;
        loop = 1'b1;
        acc = 0;
        guard = 0;
        tx_en0 = 1'b1;
        while (acc < 3 && guard < 1000) begin
            if (!tx_busy0) begin
                tx_data0 = bb[acc];
                q0.push_back(mk(bb[acc], 1'b0));
                stamp[acc] = cyc;
                acc++;
                exp_tx++;
            end else begin
                tx_data0 = 8'($urandom);
            end
            guard++;
            @(negedge clk);
        end
        tx_en0 = 1'b0;
        chk("b2b_accepted", 32'(acc), 32'd3);
        chk("b2b_gap01", 32'(stamp[1] - stamp[0]), 32'd161);
        chk("b2b_gap12", 32'(stamp[2] - stamp[1]), 32'd161);
        repeat (200) @(negedge clk);
        chk("b2b_all_received", 32'(q0.size()), 32'd0);

        // two-cycle low glitch must not start a frame
        loop = 1'b0;
        clk_per_bit = 8'd10;
        n0 = ndone0;
        rx_drv0 = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv0 = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_done", 32'(ndone0), 32'(n0));
        q0.push_back(mk(8'h5A, 1'b0));
        send_rx(1'b0, 8'h5A, 1'b0, 1'b1, 10);
        repeat (20) @(negedge clk);
        chk("glitch_recover", 32'(ndone0), 32'(n0 + 1));

        // even parity receiver
        clk_per_bit = 8'd8;
        q1.push_back(mk(8'h07, 1'b1));
        send_rx(1'b1, 8'h07, 1'b0, 1'b1, 8);
        repeat (8) @(negedge clk);
        chk("perr_hold", 32'(rx_perr1), 32'd1);
        chk("rx1_data_hold", 32'(rx_data1), 32'h07);
        q1.push_back(mk(8'h07, 1'b0));
        send_rx(1'b1, 8'h07, 1'b1, 1'b1, 8);
        repeat (8) @(negedge clk);
        q1.push_back(mk(8'h81, 1'b0));
        send_rx(1'b1, 8'h81, 1'b0, 1'b0, 8);
        repeat (12) @(negedge clk);
        q1.push_back(mk(8'h3C, 1'b0));
        send_rx(1'b1, 8'h3C, 1'b0, 1'b1, 8);
        repeat (10) @(negedge clk);
        chk("par_all_received", 32'(q1.size()), 32'd0);
        chk("par_done_count", 32'(ndone1), 32'd4);

        // reset in the middle of TX data and RX data (loopback)
        clk_per_bit = 8'd8;
        loop = 1'b1;
        n0 = ndone0;
        t0 = ntxdone;
        tx_data0 = 8'hC3;
        tx_en0 = 1'b1;
        @(negedge clk);
        tx_en0 = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_busy", 32'(tx_busy0), 32'd1);
        chk("mid_tx_low", 32'(tx_out0), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx_out", 32'(tx_out0), 32'd1);
        chk("async_tx_busy", 32'(tx_busy0), 32'd0);
        chk("async_rx_data", 32'(rx_data0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        chk("abort_no_rx_done", 32'(ndone0), 32'(n0));
        chk("abort_no_tx_done", 32'(ntxdone), 32'(t0));

        rv = '{8'h96, 8'd8, 1'b1, {1'b1, 8'h96, 1'b0}};
        tx_frame(rv);
        repeat (10) @(negedge clk);
        chk("recover_received", 32'(q0.size()), 32'd0);
        chk("tx_done_count", 32'(ntxdone), 32'(exp_tx));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/uart_txrx_wrapper.md
Name: uart_txrx_wrapper

Overview:
Full-duplex UART core with a runtime-programmable baud divider: one transmitter and one receiver sharing a clock and reset. It sits under the UART-to-AXI-stream bridge, which drives TX_en/TX_dataIn from the incoming stream (ready = !TX_busy) and captures RX_dataOut on each RX_done pulse. Frame format is fixed by parameters: start bit, DATA_WIDTH data bits LSB first, optional parity, then stop bits.

Parameters:
CLK_BITS, 8, width of clk_per_bit (clock cycles per bit).
DATA_WIDTH, 8, data bits per frame.
PARITY_BITS, 0, 0 = no parity; 1 = one even-parity bit.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
clk_per_bit  input  CLK_BITS  clock cycles per serial bit; 0 treated as 1.
TX_dataIn  input  DATA_WIDTH  byte to transmit, sampled when accepted.
TX_en  input  1  transmit request; accepted only when TX_busy=0.
RX_dataIn  input  1  serial RX pin, asynchronous.
TX_out  output  1  serial TX pin, idle high.
TX_done  output  1  one-cycle pulse when the last stop bit completes.
TX_busy  output  1  high while a frame is in flight.
RX_dataOut  output  DATA_WIDTH  last received byte.
RX_done  output  1  one-cycle pulse, RX_dataOut valid in same cycle.
RX_parityError  output  1  parity mismatch of last frame.

Behaviour:
- Reset: TX_out=1, TX_busy=0, TX_done=0, RX_done=0, RX_dataOut=0, RX_parityError=0, both FSMs IDLE, counters 0. Reset mid-frame aborts immediately; no done pulse.
- clk_per_bit latched at frame start (TX acceptance / RX start detect); changes mid-frame ignored.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_BITS=1) -> STOP -> IDLE.
- TX: TX_en=1 and TX_busy=0 in cycle N latches TX_dataIn; from cycle N+1 TX_busy=1 and TX_out=0 (start). Each bit lasts exactly clk_per_bit cycles. Data LSB first; parity = XOR of data bits; stop bits = 1.
- Frame length = (1+DATA_WIDTH+PARITY_BITS+STOP_BITS)*clk_per_bit cycles. In the final cycle of the last stop bit TX_done pulses; TX_busy=0 from the next cycle. TX_en in that next cycle starts a new frame back-to-back.
- TX_en while busy: ignored, no queuing.
- RX input: 2-flop synchronizer; all RX timing is relative to the synchronized signal.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
- Start: in IDLE, a synchronized 1->0 transition enters START. Wait clk_per_bit/2 cycles (integer floor, minimum 1) and resample. If the line is high, treat as a glitch and return to IDLE. Otherwise sample every clk_per_bit cycles at mid-bit.
- Data shifts in LSB first. Parity sampled and compared to XOR of data bits.
- RX_done: at the mid-bit sample of the first stop bit, RX_done pulses for one cycle. RX_dataOut and RX_parityError update in that same cycle and hold until the next RX_done.
- Extra stop bits are not checked. A low stop bit (framing error) still delivers the byte; there is no framing-error output.
- RX returns to IDLE after the RX_done cycle and can detect a new start edge immediately.
- TX and RX are fully independent; simultaneous activity is allowed.

Decomposition:
- Package uart_pkg: tx_state_e and rx_state_e enums (IDLE, START, DATA, PARITY, STOP) and a parity-compute function.
- Two sub-modules, uart_tx and uart_rx, instantiated by uart_txrx_wrapper. The wrapper only wires ports, parameters and reset.

Test Plan:
- clk_per_bit=8, TX_en pulse with 0xA5: TX_out shows 0,1,0,1,0,0,1,0,1 then 1 (stop), each 8 cycles. TX_busy is high for 80 cycles. TX_done pulses once in the last cycle.
- Loopback TX_out->RX_dataIn, clk_per_bit=16, send 0x00, 0xFF, 0x3C back-to-back: three RX_done pulses with RX_dataOut 0x00, 0xFF, 0x3C; RX_parityError=0.
- PARITY_BITS=1, drive RX with 0x07 and parity bit 0 (correct bit is 1): RX_done pulses, RX_dataOut=0x07, RX_parityError=1. Next correct frame clears it to 0.
- RX low glitch of 2 cycles with clk_per_bit=10: no RX_done; receiver returns to IDLE and the next valid frame decodes correctly.
- TX_en held high continuously with data changing every cycle: only the bytes present in acceptance cycles (TX_busy=0) are transmitted.
- Assert rst_n=0 mid-TX-data and mid-RX-data: TX_out=1 and TX_busy=0 immediately; no done pulses. A subsequent frame after reset release works normally.
